dds_ram_ctrl: RTL and testbench

- Single-clock sequencer for the simple dual-port waveform RAM in the RAM/DDS datapath.
- Loads a waveform table into the RAM through a valid/ready stream, then runs a phase accumulator that addresses the RAM read port.
- Emits a latency-aligned sample stream (dds_valid/dds_data).
- Owns every RAM port. Load and playback are mutually exclusive, so no read/write collision ever occurs.

---
 rtl/dds_ram_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_dds_ram_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_ram_ctrl.sv
// dds_ram_ctrl: waveform RAM sequencer. Loads a table through a valid/ready
// stream, then plays it back through a phase accumulator on the RAM read port.
// The RAM sees its read address on the same cycle the RUN state issues it.
// It returns the data RD_LAT cycles later. The controller passes that data
// straight through while its matching valid bit is set, and holds the last
// sample at other times.
// Optional build macro: DDS_LIVE_TUNE_EN. When it is defined, ftw/pow are
// taken directly from the ports on every RUN cycle. When it is undefined, they
// are captured on the accepted start.
`timescale 1ns/1ps

module dds_ram_ctrl #(
  parameter  int unsigned DATA_WIDTH  = 8,
  parameter  int unsigned DATA_DEPTH  = 256,
  parameter  int unsigned PHASE_WIDTH = 32,
  parameter  int unsigned RD_LAT      = 2,
  localparam int unsigned AW          = $clog2(DATA_DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_req,
  input  logic                   start,
  input  logic                   stop,
  input  logic [PHASE_WIDTH-1:0] ftw,
  input  logic [PHASE_WIDTH-1:0] pow,
  input  logic                   ld_valid,
  input  logic [DATA_WIDTH-1:0]  ld_data,
  output logic                   ld_ready,
  output logic                   ld_done,
  output logic                   table_valid,
  output logic                   start_err,
  output logic                   busy,
  output logic                   ram_wen,
  output logic [AW-1:0]          ram_w_addr,
  output logic [DATA_WIDTH-1:0]  ram_w_data,
  output logic [AW-1:0]          ram_r_addr,
  input  logic [DATA_WIDTH-1:0]  ram_r_data,
  output logic                   dds_valid,
  output logic [DATA_WIDTH-1:0]  dds_data
);

  localparam int unsigned CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_e;

  state_e                   state_q, state_d;
  logic [AW-1:0]            wr_cnt_q, wr_cnt_d;
  logic [PHASE_WIDTH-1:0]   phase_q, phase_d;
  logic [CW-1:0]            drain_cnt_q, drain_cnt_d;
  logic [RD_LAT-1:0]        vld_q, vld_d;
  logic [AW-1:0]            r_addr_q;
  logic [DATA_WIDTH-1:0]    dds_hold_q;
  logic                     table_valid_q, table_valid_d;
  logic                     ld_done_q, ld_done_d;
  logic                     start_err_q, start_err_d;
  logic                     issue;
  logic                     ld_accept;
  logic [AW-1:0]            rd_addr_c;
  logic [PHASE_WIDTH-1:0]   ftw_use, pow_use, phase_sum;

`ifdef DDS_LIVE_TUNE_EN
  // Tuning words track the ports on every RUN cycle.
  assign ftw_use = ftw;
  assign pow_use = pow;
`else
  logic [PHASE_WIDTH-1:0] ftw_l_q, ftw_l_d, pow_l_q, pow_l_d;

  // Capture the tuning words only on a start that enters RUN.
  always_comb begin
    ftw_l_d = ftw_l_q;
    pow_l_d = pow_l_q;
    if (state_q == IDLE && !load_req && start && table_valid_q) begin
      ftw_l_d = ftw;
      pow_l_d = pow;
    end
  end

  // Tuning word registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ftw_l_q <= '0;
      pow_l_q <= '0;
    end else begin
      ftw_l_q <= ftw_l_d;
      pow_l_q <= pow_l_d;
    end
  end

  assign ftw_use = ftw_l_q;
  assign pow_use = pow_l_q;
`endif

  assign phase_sum = phase_q + pow_use;

  // Next-state logic, load/playback counters and pulse outputs.
  always_comb begin
    state_d       = state_q;
    wr_cnt_d      = wr_cnt_q;
    phase_d       = phase_q;
    drain_cnt_d   = drain_cnt_q;
    table_valid_d = table_valid_q;
    ld_done_d     = 1'b0;
    start_err_d   = 1'b0;
    issue         = 1'b0;
    ld_accept     = 1'b0;
    rd_addr_c     = r_addr_q;
    case (state_q)
      IDLE: begin
        if (load_req) begin
          state_d       = LOAD;
          table_valid_d = 1'b0;
          wr_cnt_d      = '0;
        end else if (start) begin
          if (table_valid_q) begin
            state_d = RUN;
            phase_d = '0;
          end else begin
            start_err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (ld_valid) begin
          ld_accept = 1'b1;
          wr_cnt_d  = wr_cnt_q + AW'(1);
          if (wr_cnt_q == AW'(DATA_DEPTH - 1)) begin
            state_d       = IDLE;
            ld_done_d     = 1'b1;
            table_valid_d = 1'b1;
          end
        end
      end
      RUN: begin
        issue     = 1'b1;
        rd_addr_c = phase_sum[PHASE_WIDTH-1 -: AW];
        phase_d   = phase_q + ftw_use;
        if (stop) begin
          state_d     = DRAIN;
          drain_cnt_d = '0;
        end
      end
      DRAIN: begin
        if (drain_cnt_q == CW'(RD_LAT - 1)) begin
          state_d = IDLE;
        end else begin
          drain_cnt_d = drain_cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Valid shift register mirrors reads in flight through the RAM.
  always_comb begin
    vld_d    = '0;
    vld_d[0] = issue;
    for (int i = 1; i < int'(RD_LAT); i++) begin
      vld_d[i] = vld_q[i-1];
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      wr_cnt_q      <= '0;
      phase_q       <= '0;
      drain_cnt_q   <= '0;
      vld_q         <= '0;
      r_addr_q      <= '0;
      dds_hold_q    <= '0;
      table_valid_q <= 1'b0;
      ld_done_q     <= 1'b0;
      start_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_cnt_q      <= wr_cnt_d;
      phase_q       <= phase_d;
      drain_cnt_q   <= drain_cnt_d;
      vld_q         <= vld_d;
      r_addr_q      <= rd_addr_c;
      dds_hold_q    <= dds_data;
      table_valid_q <= table_valid_d;
      ld_done_q     <= ld_done_d;
      start_err_q   <= start_err_d;
    end
  end

  assign ld_ready    = (state_q == LOAD);
  assign busy        = (state_q != IDLE);
  assign ld_done     = ld_done_q;
  assign table_valid = table_valid_q;
  assign start_err   = start_err_q;
  assign ram_wen     = ld_accept;
  assign ram_w_addr  = ld_accept ? wr_cnt_q : '0;
  assign ram_w_data  = ld_accept ? ld_data : '0;
  assign ram_r_addr  = rd_addr_c;
  assign dds_valid   = vld_q[RD_LAT-1];
  assign dds_data    = dds_valid ? ram_r_data : dds_hold_q;

endmodule

// File: tb/tb_dds_ram_ctrl.sv
// tb_dds_ram_ctrl: bench for dds_ram_ctrl with a 2-cycle RAM model.
`timescale 1ns/1ps

module tb_dds_ram_ctrl;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 256;
  localparam int unsigned PW    = 32;
  localparam int unsigned AW    = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_req, start, stop;
  logic [PW-1:0] ftw, pow;
  logic          ld_valid;
  logic [DW-1:0] ld_data;
  logic          ld_ready, ld_done, table_valid, start_err, busy;
  logic          ram_wen;
  logic [AW-1:0] ram_w_addr, ram_r_addr;
  logic [DW-1:0] ram_w_data, ram_r_data;
  logic          dds_valid;
  logic [DW-1:0] dds_data;

  always #5 clk = ~clk;

  dds_ram_ctrl #(.DATA_WIDTH(DW), .DATA_DEPTH(DEPTH), .PHASE_WIDTH(PW), .RD_LAT(2)) dut (
    .clk(clk), .rst(rst), .load_req(load_req), .start(start), .stop(stop),
    .ftw(ftw), .pow(pow), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(ld_ready), .ld_done(ld_done), .table_valid(table_valid),
    .start_err(start_err), .busy(busy), .ram_wen(ram_wen),
    .ram_w_addr(ram_w_addr), .ram_w_data(ram_w_data), .ram_r_addr(ram_r_addr),
    .ram_r_data(ram_r_data), .dds_valid(dds_valid), .dds_data(dds_data)
  );

  // Simple dual-port RAM: registered read address plus registered read data.
  logic [DW-1:0] mem [0:DEPTH-1];
  logic [AW-1:0] ra_q;
  logic [DW-1:0] rd_q;
  always @(posedge clk) begin
    if (ram_wen) mem[ram_w_addr] <= ram_w_data;
    ra_q <= ram_r_addr;
    rd_q <= mem[ra_q];
  end
  assign ram_r_data = rd_q;

  typedef struct {
    logic [31:0] ftw;
    logic [31:0] pow;
    int          nsamp;
    logic [7:0]  e0;
    logic [7:0]  e1;
  } vec_t;

  vec_t        vecs [5];
  vec_t        rv;
  int          checks   = 0;
  int          failures = 0;
  logic [7:0]  sb [$];
  logic [7:0]  exp_mem [0:DEPTH-1];
  logic [7:0]  first_d [2];
  int          pop_idx;
  logic [7:0]  last_addr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Negedge of the current cycle: drain the scoreboard and police write enables.
  task automatic neg();
    @(negedge clk);
    chk("wen_outside_load", 32'(ram_wen & ~ld_ready), 32'd0);
    if (dds_valid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL dds_unexpected actual=%0h expected=none t=%0t", dds_data, $time);
      end else begin
        logic [7:0] e;
        e = sb.pop_front();
        chk("dds_data", 32'(dds_data), 32'(e));
        if (pop_idx < 2) first_d[pop_idx] = dds_data;
        pop_idx++;
      end
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Load a full table; optional start in the request cycle, optional bubbles.
  task automatic load_table(input bit with_start, input bit bubbles, input logic [7:0] xr);
    int idx;
    int cyc;
    load_req = 1'b1;
    start    = with_start;
    neg();
    next();
    load_req = 1'b0;
    start    = 1'b0;
    idx = 0;
    cyc = 0;
    while (idx < int'(DEPTH) && cyc < 600) begin
      bit v;
      v        = !(bubbles && (cyc % 5 == 2));
      ld_valid = v;
      ld_data  = 8'(idx) ^ xr;
      neg();
      if (cyc == 0) begin
        chk("ld_ready_load", 32'(ld_ready), 32'd1);
        chk("busy_load", 32'(busy), 32'd1);
        chk("start_err_load", 32'(start_err), 32'd0);
        chk("table_valid_cleared", 32'(table_valid), 32'd0);
        chk("rd_addr_hold", 32'(ram_r_addr), 32'(last_addr));
        chk("dds_valid_load", 32'(dds_valid), 32'd0);
      end
      chk("wen", 32'(ram_wen), 32'(v));
      if (v) begin
        chk("w_addr", 32'(ram_w_addr), 32'(idx));
        chk("w_data", 32'(ram_w_data), 32'(8'(idx) ^ xr));
        exp_mem[idx] = 8'(idx) ^ xr;
        idx++;
      end
      next();
      cyc++;
    end
    if (idx < int'(DEPTH)) begin
      checks++;
      failures++;
      $display("FAIL load_timeout actual=%0d expected=%0d", idx, DEPTH);
    end
    ld_valid = 1'b0;
    neg();
    chk("ld_done", 32'(ld_done), 32'd1);
    chk("table_valid_set", 32'(table_valid), 32'd1);
    chk("busy_after_load", 32'(busy), 32'd0);
    chk("ld_ready_after_load", 32'(ld_ready), 32'd0);
    next();
    neg();
    chk("ld_done_pulse", 32'(ld_done), 32'd0);
    next();
  endtask

  // Start, run nsamp RUN cycles (stop on the last one), then check the drain.
  task automatic play(input vec_t v);
    pop_idx = 0;
    ftw     = v.ftw;
    pow     = v.pow;
    start   = 1'b1;
    neg();
    next();
    start = 1'b0;
    for (int k = 0; k < v.nsamp; k++) begin
      logic [31:0] ph;
      ph = v.ftw * 32'(k) + v.pow;
      sb.push_back(exp_mem[ph[31:24]]);
      last_addr = ph[31:24];
      stop      = (k == v.nsamp - 1);
      start     = (k == v.nsamp - 1);
      load_req  = (k == 1);
`ifndef DDS_LIVE_TUNE_EN
      ftw = $urandom;
      pow = $urandom;
`endif
      neg();
      if (k < 2) chk("lat_pre", 32'(dds_valid), 32'd0);
      else if (k == 2) chk("lat_first", 32'(dds_valid), 32'd1);
      if (k == 1) chk("run_ignores_load", 32'(ld_ready), 32'd0);
      next();
    end
    stop     = 1'b0;
    start    = 1'b0;
    load_req = 1'b0;
    for (int d = 0; d < 2; d++) begin
      neg();
      chk("drain_valid", 32'(dds_valid), 32'd1);
      chk("drain_busy", 32'(busy), 32'd1);
      next();
    end
    neg();
    chk("post_drain_valid", 32'(dds_valid), 32'd0);
    chk("post_drain_busy", 32'(busy), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    chk("first_sample", 32'(first_d[0]), 32'(v.e0));
    chk("second_sample", 32'(first_d[1]), 32'(v.e1));
    next();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{32'h0100_0000, 32'h0000_0000, 260, 8'h00, 8'h01};
    vecs[1] = '{32'h8000_0000, 32'h4000_0000,   8, 8'h40, 8'hC0};
    vecs[2] = '{32'hFF00_0000, 32'h0000_0000,   6, 8'h00, 8'hFF};
    vecs[3] = '{32'h0080_0000, 32'h1000_0000,  10, 8'h10, 8'h10};
    vecs[4] = '{32'h0000_0000, 32'h7F00_0000,   5, 8'h7F, 8'h7F};
    rv      = '{32'h8000_0000, 32'h4000_0000,   6, 8'hE5, 8'h65};

    rst = 1'b1; load_req = 0; start = 0; stop = 0; ftw = 0; pow = 0;
    ld_valid = 0; ld_data = 0; pop_idx = 0; last_addr = 0;
    first_d[0] = 0; first_d[1] = 0;

    neg();
    chk("rst_ld_ready", 32'(ld_ready), 32'd0);
    chk("rst_table_valid", 32'(table_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_dds_valid", 32'(dds_valid), 32'd0);
    chk("rst_dds_data", 32'(dds_data), 32'd0);
    chk("rst_r_addr", 32'(ram_r_addr), 32'd0);
    chk("rst_ld_done_err", 32'({ld_done, start_err, ram_wen}), 32'd0);
    next();
    next();
    rst = 1'b0;
    next();

    // Start with no table resident.
    start = 1'b1;
    neg();
    next();
    start = 1'b0;
    neg();
    chk("start_err_pulse", 32'(start_err), 32'd1);
    chk("start_err_busy", 32'(busy), 32'd0);
    next();
    neg();
    chk("start_err_single", 32'(start_err), 32'd0);
    chk("start_err_no_read", 32'(ram_r_addr), 32'd0);
    chk("start_err_no_valid", 32'(dds_valid), 32'd0);
    next();

    // Ramp load, with start colliding with load_req.
    load_table(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) play(vecs[i]);

    // Reload a scrambled table with stream bubbles and play it back.
    load_table(1'b0, 1'b1, 8'hA5);
    play(rv);

    // Reset in the middle of a load.
    load_req = 1'b1;
    neg();
    next();
    load_req = 1'b0;
    for (int i = 0; i < 100; i++) begin
      ld_valid = 1'b1;
      ld_data  = 8'(i);
      neg();
      next();
    end
    ld_valid = 1'b1;
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_ld_ready", 32'(ld_ready), 32'd0);
    chk("midrst_wen", 32'(ram_wen), 32'd0);
    chk("midrst_table_valid", 32'(table_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    ld_valid = 1'b0;
    neg();
    next();
    rst = 1'b0;
    next();
    start = 1'b1;
    neg();
    next();
    start = 1'b0;
    neg();
    chk("midrst_start_err", 32'(start_err), 32'd1);
    chk("midrst_start_busy", 32'(busy), 32'd0);
    next();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
